rpn_stack_ctrl: RTL
===================

Name: rpn_stack_ctrl

Overview:
- Token-driven RPN evaluator that sits directly upstream of stack_8x8 and is the only master of its cmd/data_in port.
- Accepts operand, operator and clear tokens over a valid/ready handshake.
- Turns each token into push/pop/clr command sequences and computes binary results from the two top entries.
- Pushes each result back onto the stack and reports it on a one-cycle result strobe.

Parameters:
WIDTH, 8, data width of tokens, stack entries and results; must match stack_8x8 (8).

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
tok_valid  input  1  token present
tok_ready  output  1  controller can accept a token this cycle
tok_kind  input  2  0=OPERAND, 1=OPERATOR, 2=CLEAR, 3=reserved
tok_data  input  WIDTH  operand value; for OPERATOR, [1:0] is the opcode
res_valid  output  1  one-cycle strobe, res_data valid
res_data  output  WIDTH  last computed result
err  output  1  sticky error flag
stk_cmd  output  2  to stack cmd: 0=NOP, 1=CLR, 2=PUSH, 3=POP
stk_data_in  output  WIDTH  to stack data_in
stk_data_out  input  WIDTH  from stack data_out
stk_full  input  1  from stack full
stk_empty  input  1  from stack empty (monitor only)
stk_error  input  1  from stack error

Behaviour:
- Stack contract:
  - The stack samples stk_cmd at a rising edge.
  - The popped value, stk_error and the updated full/empty flags are valid in the cycle after that edge.
- Outputs:
  - stk_cmd, stk_data_in, res_valid, res_data and err are registered.
  - stk_cmd defaults to NOP each cycle unless a state issues a command.
  - tok_ready = (state==IDLE), combinational.
- Reset (rst_n low at an edge):
  - state=IDLE, stk_cmd=CLR (stack is cleared every reset cycle), stk_data_in=0, res_valid=0, res_data=0, err=0.
  - Reset aborts any in-flight sequence; captured operands are discarded.
- States: IDLE, POP1, POP2, CALC, WAIT.
- IDLE, on tok_valid&&tok_ready:
  - OPERAND, stk_full=0: stk_cmd<=PUSH, stk_data_in<=tok_data, go WAIT.
  - OPERAND, stk_full=1: err<=1, no command issued, remain IDLE.
  - OPERATOR: op<=tok_data[1:0], stk_cmd<=POP, go POP1.
  - CLEAR: stk_cmd<=CLR, err<=0, go WAIT.
  - Reserved kind: accepted and discarded, remain IDLE.
- POP1: stk_cmd<=POP, go POP2.
- POP2:
  - Capture B<=stk_data_out (top-of-stack).
  - If stk_error: err<=1, go WAIT; the pending second pop is harmless.
  - Else go CALC.
- CALC:
  - Capture A<=stk_data_out.
  - If stk_error: err<=1, no push, no res_valid, go WAIT. B is lost and the stack is left empty.
  - Else compute R, then stk_cmd<=PUSH, stk_data_in<=R, res_data<=R, res_valid<=1, go WAIT.
- WAIT: one settle cycle so flags reflect the last command, then go IDLE.
- Timing, with the accept cycle = t0:
  - OPERAND: PUSH on stk_cmd at t1, tok_ready high again at t2.
  - OPERATOR: POP at t1 and t2, res_valid and PUSH at t4, tok_ready high at t5.
- Arithmetic, all results modulo 2^WIDTH with no flags:
  - op0: A+B
  - op1: A-B (A is the deeper entry)
  - op2: A&B
  - op3: see Optional Feature
- Error rules:
  - err is sticky and is cleared only by a CLEAR token or reset.
  - The controller keeps accepting tokens while err=1.

Optional Feature:
RPN_MUL_EN
- Defined: op3 = low WIDTH bits of A*B.
- Undefined: op3 = A^B; no multiplier is synthesised.

Test Plan:
- Reset then push 0x05, push 0x03, operator op1 -> res_valid pulses 4 cycles after operator accept with res_data=0x02; stack then holds the single entry 0x02; err=0.
- Push 0x03, push 0x05, op1 -> res_data=0xFE (wrap); then push 0xF0, op0 -> res_data=0xEE; then push 0x0F, op2 -> res_data=0x0E.
- From reset, operator op0 with an empty stack -> err=1, no res_valid, tok_ready high 4 cycles after accept; then CLEAR -> err=0.
- Push 0x01..0x08, then push 0x09 -> no PUSH issued, err=1; next eight operator-free pops via op0 chain yield sum 0x24 with err still 1.
- Push 0x0C, push 0x0A, op3 -> res_data=0x78 with RPN_MUL_EN defined, 0x06 without.
- Drive rst_n low for one edge while in POP2 during an op0 -> next cycle state IDLE, stk_cmd=CLR, res_valid=0, err=0, no result pushed.

Source files
------------

// File: rtl/rpn_stack_ctrl.sv
// Token-driven RPN evaluator that masters the stack_8x8 cmd/data_in port.
// Build option: define RPN_MUL_EN to make opcode 3 a multiply (otherwise XOR).
module rpn_stack_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tok_valid,
  output logic             tok_ready,
  input  logic [1:0]       tok_kind,
  input  logic [WIDTH-1:0] tok_data,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic             err,
  output logic [1:0]       stk_cmd,
  output logic [WIDTH-1:0] stk_data_in,
  input  logic [WIDTH-1:0] stk_data_out,
  input  logic             stk_full,
  input  logic             stk_empty,
  input  logic             stk_error
);

  typedef enum logic [2:0] {IDLE, POP1, POP2, CALC, WAIT} state_e;
  typedef enum logic [1:0] {CMD_NOP = 2'd0, CMD_CLR = 2'd1, CMD_PUSH = 2'd2, CMD_POP = 2'd3} cmd_e;
  typedef enum logic [1:0] {TOK_OPERAND = 2'd0, TOK_OPERATOR = 2'd1, TOK_CLEAR = 2'd2, TOK_RSVD = 2'd3} kind_e;

  state_e           state, state_d;
  cmd_e             cmd_q, cmd_d;
  logic [WIDTH-1:0] data_in_d;
  logic             res_valid_d;
  logic [WIDTH-1:0] res_data_d;
  logic             err_d;
  logic [1:0]       op, op_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] alu_r;

  // Empty flag is observed by the stack's other consumers only.
  logic unused_empty;
  assign unused_empty = stk_empty;

  assign tok_ready = (state == IDLE);
  assign stk_cmd   = cmd_q;

  // A is the deeper entry; it is consumed straight off stk_data_out in CALC.
  always_comb begin
    alu_r = '0;
    case (op)
      2'd0: alu_r = stk_data_out + b_q;
      2'd1: alu_r = stk_data_out - b_q;
      2'd2: alu_r = stk_data_out & b_q;
      default: begin
`ifdef RPN_MUL_EN
        alu_r = stk_data_out * b_q;
`else
        alu_r = stk_data_out ^ b_q;
`endif
      end
    endcase
  end

  always_comb begin
    state_d     = state;
    cmd_d       = CMD_NOP;
    data_in_d   = stk_data_in;
    res_valid_d = 1'b0;
    res_data_d  = res_data;
    err_d       = err;
    op_d        = op;
    b_d         = b_q;
    case (state)
      IDLE: begin
        if (tok_valid) begin
          case (kind_e'(tok_kind))
            TOK_OPERAND: begin
              if (stk_full) begin
                err_d = 1'b1;
              end else begin
                cmd_d     = CMD_PUSH;
                data_in_d = tok_data;
                state_d   = WAIT;
              end
            end
            TOK_OPERATOR: begin
              op_d    = tok_data[1:0];
              cmd_d   = CMD_POP;
              state_d = POP1;
            end
            TOK_CLEAR: begin
              cmd_d   = CMD_CLR;
              err_d   = 1'b0;
              state_d = WAIT;
            end
            default: ;
          endcase
        end
      end
      POP1: begin
        cmd_d   = CMD_POP;
        state_d = POP2;
      end
      POP2: begin
        b_d = stk_data_out;
        if (stk_error) begin
          err_d   = 1'b1;
          state_d = WAIT;
        end else begin
          state_d = CALC;
        end
      end
      CALC: begin
        if (stk_error) begin
          err_d = 1'b1;
        end else begin
          cmd_d       = CMD_PUSH;
          data_in_d   = alu_r;
          res_data_d  = alu_r;
          res_valid_d = 1'b1;
        end
        state_d = WAIT;
      end
      WAIT:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cmd_q       <= CMD_CLR;
      stk_data_in <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      err         <= 1'b0;
      op          <= '0;
      b_q         <= '0;
    end else begin
      state       <= state_d;
      cmd_q       <= cmd_d;
      stk_data_in <= data_in_d;
      res_valid   <= res_valid_d;
      res_data    <= res_data_d;
      err         <= err_d;
      op          <= op_d;
      b_q         <= b_d;
    end
  end

endmodule
